hazard5_muldiv_issue: RTL and testbench

Execute-stage front end for hazard5_muldiv_seq. Accepts M-extension ops from X stage, stalls the pipeline, drives the sequencer handshake and selects the required half of its result. Holds a one-entry result cache so that paired ops on identical operands return without recomputation: MULH*→MUL, DIV→REM, DIVU→REMU. Kill from the pipeline aborts an in-flight op.

---
 rtl/hazard5_muldiv_issue.sv | 90 +++++++++
 tb/tb_hazard5_muldiv_issue.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard5_muldiv_issue.sv
// hazard5_muldiv_issue: X-stage front end for the mul/div sequencer with a one-entry paired-op result cache
module hazard5_muldiv_issue #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      x_op,
  input  logic            x_op_vld,
  input  logic [XLEN-1:0] x_op_a,
  input  logic [XLEN-1:0] x_op_b,
  input  logic            x_kill,
  output logic            x_stall,
  output logic [XLEN-1:0] x_result,
  output logic            x_result_vld,
  output logic [2:0]      m_op,
  output logic            m_op_vld,
  input  logic            m_op_rdy,
  output logic            m_op_kill,
  output logic [XLEN-1:0] m_op_a,
  output logic [XLEN-1:0] m_op_b,
  input  logic [XLEN-1:0] m_result_h,
  input  logic [XLEN-1:0] m_result_l,
  input  logic            m_result_vld
);
  localparam logic [2:0] M_OP_MUL = 3'd0;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_nxt;
  logic c_vld;
  logic [2:0] c_op;
  logic [XLEN-1:0] c_a, c_b, c_h, c_l;
  logic accept, hit, hit_op, seq_done;
  function automatic logic sel_h(input logic [2:0] op);
    return op[2] ? op[1] : |op[1:0];
  endfunction
  // x_op_vld is still held during the strobe cycle, so it must not be re-accepted then
  assign accept   = state == IDLE && x_op_vld && !x_kill && !x_result_vld;
  assign hit_op   = x_op == M_OP_MUL ? !c_op[2] : !x_op[2] ? c_op == x_op : c_op[2] && c_op[0] == x_op[0];
  assign hit      = c_vld && c_a == x_op_a && c_b == x_op_b && hit_op;
  assign seq_done = state == WAIT && m_result_vld && !x_kill;
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? (hit ? DONE : ISSUE) : IDLE;
      ISSUE:   state_nxt = x_kill ? IDLE : m_op_rdy ? WAIT : ISSUE;
      WAIT:    state_nxt = x_kill ? IDLE : m_result_vld ? DONE : WAIT;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    x_stall   = x_op_vld && !x_result_vld && !x_kill;
    m_op_kill = (state == ISSUE || state == WAIT) && x_kill;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      x_result     <= '0;
      x_result_vld <= 1'b0;
      m_op         <= '0;
      m_op_vld     <= 1'b0;
      m_op_a       <= '0;
      m_op_b       <= '0;
      c_vld        <= 1'b0;
      c_op         <= '0;
      c_a          <= '0;
      c_b          <= '0;
      c_h          <= '0;
      c_l          <= '0;
    end else begin
      x_result_vld <= state == DONE && !x_kill;
      if (accept && hit) x_result <= sel_h(x_op) ? c_h : c_l;
      if (accept && !hit) begin
        m_op     <= x_op;
        m_op_a   <= x_op_a;
        m_op_b   <= x_op_b;
        m_op_vld <= 1'b1;
      end
      if (state == ISSUE && (x_kill || m_op_rdy)) m_op_vld <= 1'b0;
      if (seq_done) begin
        x_result <= sel_h(m_op) ? m_result_h : m_result_l;
        c_vld    <= 1'b1;
        c_op     <= m_op;
        c_a      <= m_op_a;
        c_b      <= m_op_b;
        c_h      <= m_result_h;
        c_l      <= m_result_l;
      end
    end
endmodule

// File: tb/tb_hazard5_muldiv_issue.sv
// tb_hazard5_muldiv_issue: scoreboard bench with a behavioural sequencer model
module tb_hazard5_muldiv_issue;
  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;
  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] x_op;
  logic x_op_vld, x_kill, x_stall, x_result_vld;
  logic [31:0] x_op_a, x_op_b, x_result;
  logic [2:0] m_op;
  logic m_op_vld, m_op_rdy, m_op_kill, m_result_vld;
  logic [31:0] m_op_a, m_op_b, m_result_h, m_result_l;
  int total = 0;
  int bad = 0;
  logic [31:0] sb[$];
  hazard5_muldiv_issue #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .x_op(x_op), .x_op_vld(x_op_vld), .x_op_a(x_op_a),
    .x_op_b(x_op_b), .x_kill(x_kill), .x_stall(x_stall), .x_result(x_result),
    .x_result_vld(x_result_vld), .m_op(m_op), .m_op_vld(m_op_vld), .m_op_rdy(m_op_rdy),
    .m_op_kill(m_op_kill), .m_op_a(m_op_a), .m_op_b(m_op_b), .m_result_h(m_result_h),
    .m_result_l(m_result_l), .m_result_vld(m_result_vld)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] seq_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    logic [31:0] q, r;
    if (!op[2]) begin
      ea = (op == MULH || op == MULHSU) ? {{32{a[31]}}, a} : {32'd0, a};
      eb = (op == MULH) ? {{32{b[31]}}, b} : {32'd0, b};
      p = ea * eb;
      return p;
    end
    if (b == 0) begin
      q = 32'hFFFFFFFF;
      r = a;
    end else if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      q = a;
      r = 32'd0;
    end else if (!op[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction
  function automatic logic [31:0] ref_m(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    r = seq_res(op, a, b);
    return (op == MUL || op == DIV || op == DIVU) ? r[31:0] : r[63:32];
  endfunction
  logic busy;
  int cnt;
  logic [2:0] s_op;
  logic [31:0] s_a, s_b;
  always @(posedge clk) begin
    m_op_rdy <= 1'($urandom_range(0, 1));
    m_result_vld <= 1'b0;
    if (!rst_n || m_op_kill) busy <= 1'b0;
    else if (busy) begin
      if (cnt == 0) begin
        busy <= 1'b0;
        m_result_vld <= 1'b1;
        {m_result_h, m_result_l} <= seq_res(s_op, s_a, s_b);
      end else cnt <= cnt - 1;
    end else if (m_op_vld && m_op_rdy) begin
      busy <= 1'b1;
      cnt <= 3;
      s_op <= m_op;
      s_a <= m_op_a;
      s_b <= m_op_b;
    end
  end
  always @(negedge clk)
    if (x_result_vld) begin
      if (sb.size() == 0) check("unexpected_vld", 32'd1, 32'd0);
      else check("result", x_result, sb.pop_front());
    end
  task automatic check_zero_outs(input string tag);
    check({tag, "_x_result"}, x_result, 32'd0);
    check({tag, "_m_ctl"}, {26'd0, x_result_vld, m_op, m_op_vld, m_op_kill}, 32'd0);
    check({tag, "_m_op_a"}, m_op_a, 32'd0);
    check({tag, "_m_op_b"}, m_op_b, 32'd0);
  endtask
  // exp_miss / exp_lat < 0 means don't care
  task automatic req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int exp_miss, input int exp_lat);
    int n;
    logic miss;
    @(negedge clk);
    sb.push_back(exp);
    x_op = op;
    x_op_a = a;
    x_op_b = b;
    x_op_vld = 1'b1;
    n = 0;
    miss = 1'b0;
    while (1) begin
      @(negedge clk);
      n++;
      if (m_op_vld) miss = 1'b1;
      if (n == 1) check("stall", {31'd0, x_stall}, 32'd1);
      if (x_result_vld) break;
      if (n > 200) begin
        check("timeout", 32'd1, 32'd0);
        void'(sb.pop_back());
        break;
      end
    end
    x_op_vld = 1'b0;
    if (exp_miss >= 0) check("miss", {31'd0, miss}, 32'(exp_miss));
    if (exp_lat >= 0) check("latency", 32'(n), 32'(exp_lat));
  endtask
  task automatic start_to_wait(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic late);
    int n;
    logic seen;
    @(negedge clk);
    x_op = op;
    x_op_a = a;
    x_op_b = b;
    x_op_vld = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!(seen && !m_op_vld) && !(late && m_result_vld) && n < 200) begin
      @(negedge clk);
      n++;
      if (m_op_vld) seen = 1'b1;
    end
    while (late && !m_result_vld && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("wait_timeout", 32'd1, 32'd0);
  endtask
  task automatic kill_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic late);
    start_to_wait(op, a, b, late);
    x_kill = 1'b1;
    #1;
    check("kill_m_op_kill", {31'd0, m_op_kill}, 32'd1);
    check("kill_stall", {31'd0, x_stall}, 32'd0);
    @(negedge clk);
    x_kill = 1'b0;
    x_op_vld = 1'b0;
    check("kill_pulse_end", {30'd0, m_op_kill, m_op_vld}, 32'd0);
    repeat (8) @(negedge clk);
  endtask
  initial begin
    logic [31:0] pa[4] = '{32'd3, 32'd5, 32'hFFFFFFF9, 32'h80000000};
    logic [31:0] pb[4] = '{32'd2, 32'd0, 32'hFFFFFFFF, 32'd7};
    logic [2:0] op;
    logic [31:0] a, b;
    rst_n = 1'b0;
    x_op = '0;
    x_op_a = '0;
    x_op_b = '0;
    x_op_vld = 1'b0;
    x_kill = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outs("reset");
    rst_n = 1'b1;
    req(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1, -1);
    req(MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0, 2);
    req(DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1, -1);
    req(REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 0, 2);
    req(REMU, 32'hFFFFFFF9, 32'd2, 32'h00000001, 1, -1);
    req(MUL, 32'd3, 32'd5, 32'h0000000F, 1, -1);
    req(MULH, 32'd3, 32'd5, 32'h00000000, 1, -1);
    kill_op(DIVU, 32'd100, 32'd7, 1'b0);
    req(DIVU, 32'd100, 32'd7, 32'h0000000E, 1, -1);
    req(REMU, 32'd100, 32'd7, 32'h00000002, 0, 2);
    req(DIVU, 32'h1234, 32'd0, 32'hFFFFFFFF, 1, -1);
    req(REMU, 32'h1234, 32'd0, 32'h00001234, 0, 2);
    req(DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, -1);
    kill_op(DIV, 32'd9, 32'd4, 1'b1);
    req(REM, 32'd9, 32'd4, 32'h00000001, 1, -1);
    req(MULHSU, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 1, -1);
    req(MULHSU, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 0, 2);
    req(MULHU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 1, -1);
    @(negedge clk);
    x_op = DIV;
    x_op_a = 32'd50;
    x_op_b = 32'd5;
    x_op_vld = 1'b1;
    x_kill = 1'b1;
    @(negedge clk);
    x_op_vld = 1'b0;
    x_kill = 1'b0;
    check("idle_kill", {31'd0, m_op_vld}, 32'd0);
    start_to_wait(MULHU, 32'd2, 32'd3, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero_outs("midop_reset");
    rst_n = 1'b1;
    x_op_vld = 1'b0;
    repeat (2) @(negedge clk);
    req(MUL, 32'd2, 32'd3, 32'h00000006, 1, -1);
    for (int i = 0; i < 12; i++) begin
      op = 3'($urandom_range(0, 7));
      a = pa[$urandom_range(0, 3)];
      b = pb[$urandom_range(0, 3)];
      req(op, a, b, ref_m(op, a, b), -1, -1);
    end
    repeat (4) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
